multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, 16, maximum wait cycles for mem_ack_i before a timeout trap (range 2..255).
REQ-002 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  in  1  synchronous, active-low reset.
REQ-004 opcode_i  in  7  instr[6:0] from the instruction register.
REQ-005 zero_i  in  1  ALU zero flag.
REQ-006 mem_ack_i  in  1  memory completion strobe, one cycle.
REQ-007 pc_write_o  out  1  PC load enable.
REQ-008 ir_write_o  out  1  instruction-register load enable; also latches oldPC.
REQ-009 mem_req_o, mem_we_o  out  1 each  memory request and write qualifier.
REQ-010 iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 reg_write_o  out  1  register-file write enable.
REQ-012 mem_to_reg_o  out  2  write-back select: 00 ALU result, 01 MDR, 10 PC.
REQ-013 alu_src_a_o  out  2  00 PC, 01 rs1, 10 oldPC.
REQ-014 alu_src_b_o  out  2  00 rs2, 01 constant 4, 10 immediate.
REQ-015 alu_op_o  out  2  00 add, 01 subtract (branch), 10 funct-decoded; drives ALU_Ctrl.
REQ-016 pc_src_o  out  1  0 = live ALU result, 1 = ALUOut register.
REQ-017 state_o  out  4  current state encoding, debug only.
REQ-018 trap_o  out  1 and trap_cause_o  out  2: 01 illegal opcode, 10 memory timeout.

Function
REQ-019 States SHALL be: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, TRAP.
REQ-020 Outputs not listed for a state SHALL be 0.
REQ-021 FETCH: mem_req_o=1, iord_o=0, a=PC, b=4, add, pc_src_o=0; ir_write_o and pc_write_o SHALL equal mem_ack_i (Mealy). On ack go to DECODE, otherwise hold.
REQ-022 DECODE: a=oldPC, b=imm, add (branch target into ALUOut).
REQ-023 DECODE next state: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH; 1101111 -> JAL; any other opcode -> TRAP with cause 01.
REQ-024 EXEC_R: a=rs1, b=rs2, alu_op=10, next WB_ALU. EXEC_I: a=rs1, b=imm, alu_op=10, next WB_ALU.
REQ-025 WB_ALU: reg_write_o=1, mem_to_reg_o=00, next FETCH.
REQ-026 MEM_ADDR: a=rs1, b=imm, add. Next state SHALL be MEM_RD for the opcode latched in DECODE = 0000011, else MEM_WR.
REQ-027 MEM_RD: mem_req_o=1, iord_o=1; on ack go to WB_MEM. WB_MEM: reg_write_o=1, mem_to_reg_o=01, next FETCH.
REQ-028 MEM_WR: mem_req_o=1, mem_we_o=1, iord_o=1; on ack go to FETCH.
REQ-029 BRANCH: a=rs1, b=rs2, alu_op=01, pc_src_o=1, pc_write_o=zero_i, next FETCH.
REQ-030 JAL: pc_write_o=1, pc_src_o=1, reg_write_o=1, mem_to_reg_o=10, next FETCH.
REQ-031 mem_req_o SHALL stay high every cycle until mem_ack_i is sampled high; mem_ack_i while mem_req_o=0 SHALL be ignored.
REQ-032 A wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment each cycle without ack. If it reaches MEM_TIMEOUT without ack, go to TRAP with cause 10; ack in that same cycle wins.
REQ-033 TRAP: all control outputs 0, trap_o=1, cause held; leave only via reset.
REQ-034 Instruction latency SHALL be R/I/JAL/branch 3/4 cycles plus fetch wait: R 4, I 4, lw 5, sw 4, beq 3, jal 3 with zero-wait memory (ack in first request cycle).

Reset
REQ-035 rst_i low at a clock edge SHALL force state FETCH, wait counter 0, trap_o=0, trap_cause_o=00.
REQ-036 While rst_i is low all outputs SHALL be 0, including mem_req_o.
REQ-037 Reset mid-transaction SHALL abandon it with no write enable asserted; fetch restarts in the first cycle after release.

Structure
REQ-038 Package mc_ctrl_pkg SHALL hold: state enum, opcode constants, ALUOp codes, mux-select encodings, trap-cause codes, MEM_TIMEOUT default.
REQ-039 Sub-module mc_timeout_cnt SHALL implement the wait counter (clear, enable, expired).

Verification
REQ-040 add x3,x1,x2 with ack in the first cycle -> states F,D,EXEC_R,WB_ALU; reg_write_o high exactly in cycle 4.
REQ-041 lw with data ack delayed 3 cycles -> mem_req_o high 4 cycles with iord_o=1; WB_MEM with mem_to_reg_o=01.
REQ-042 beq with zero_i=1, then zero_i=0 -> pc_write_o=1 with pc_src_o=1, then pc_write_o=0; both return to FETCH.
REQ-043 opcode 0000000 -> TRAP, trap_cause_o=01; holds 20 cycles; rst_i low one edge -> FETCH, trap_o=0.
REQ-044 MEM_TIMEOUT=4, no ack in FETCH -> TRAP, cause 10; ack on the 4th wait cycle -> DECODE instead.
REQ-045 rst_i low during MEM_WR wait -> mem_req_o and mem_we_o 0 next cycle; FETCH after release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Purpose: shared types and encodings for the multi-cycle RISC-V control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum, opcode constants, ALUOp codes, mux selects, trap causes,
//           default memory timeout and the control-word struct.
package mc_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEF = 16;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MDR = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_src;
  } ctrl_t;

  // States that hold a memory request open until ack or timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_timeout_cnt.sv
// Purpose: memory-wait cycle counter; flags the last allowed wait cycle.
// Latency: expired_o is combinational from the count register.
// Backpressure: none; clr_i has priority over en_i.
// Ports: clk_i/rst_i clock and sync active-low reset, clr_i clear, en_i count
//        enable, expired_o high while this is the LIMIT-th cycle without ack.
module mc_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Count holds the number of completed no-ack cycles, so reaching LAST means
  // the current cycle is the final one in which an ack can still be accepted.
  assign expired_o = (r_cnt == LAST);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Purpose: multi-cycle RISC-V control FSM with illegal-opcode and memory-timeout traps.
// Latency: 3..5 cycles per instruction plus memory wait; outputs decode current state.
// Backpressure: memory request held high until mem_ack_i, trap after MEM_TIMEOUT cycles.
// Ports: clk_i, rst_i (sync active-low); opcode_i, zero_i, mem_ack_i inputs;
//        datapath enables/selects, state_o debug, trap_o/trap_cause_o trap status.
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ack_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       reg_write_o,
  output logic [1:0] mem_to_reg_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       pc_src_o,
  output logic [3:0] state_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o
);

  state_t     r_state;
  logic       r_trap;
  logic [1:0] r_cause;
  logic       r_is_load;

  logic  w_in_wait;
  logic  w_ack;
  logic  w_expired;
  ctrl_t w_ctl;

  assign w_in_wait = is_wait_state(r_state);
  // An ack outside a request cycle is meaningless and must not move the FSM.
  assign w_ack     = mem_ack_i & w_in_wait;

  // Clearing whenever not waiting, or on the accepting ack, guarantees a zero
  // count on entry to every wait state.
  mc_timeout_cnt #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (~w_in_wait | w_ack),
    .en_i      (w_in_wait & ~w_ack),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= S_FETCH;
      r_trap    <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_is_load <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_ack) begin
            r_state <= S_DECODE;
          end else if (w_expired) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_TIMEOUT;
          end
        end
        S_DECODE: begin
          r_is_load <= (opcode_i == OP_LOAD);
          case (opcode_i)
            OP_R:              r_state <= S_EXEC_R;
            OP_I:              r_state <= S_EXEC_I;
            OP_LOAD, OP_STORE: r_state <= S_MEM_ADDR;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            default: begin
              r_state <= S_TRAP;
              r_trap  <= 1'b1;
              r_cause <= CAUSE_ILLEGAL;
            end
          endcase
        end
        S_EXEC_R, S_EXEC_I: r_state <= S_WB_ALU;
        S_MEM_ADDR:         r_state <= r_is_load ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD, S_MEM_WR: begin
          if (w_ack) begin
            r_state <= (r_state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
          end else if (w_expired) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_TIMEOUT;
          end
        end
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_ctl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctl.mem_req   = 1'b1;
        w_ctl.alu_src_a = SRCA_PC;
        w_ctl.alu_src_b = SRCB_FOUR;
        w_ctl.alu_op    = ALU_ADD;
        // PC+4 and the new instruction are captured in the ack cycle itself.
        w_ctl.ir_write  = mem_ack_i;
        w_ctl.pc_write  = mem_ack_i;
      end
      S_DECODE: begin
        // Speculative branch/jump target oldPC+imm lands in ALUOut.
        w_ctl.alu_src_a = SRCA_OLDPC;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        w_ctl.alu_src_a = SRCA_RS1;
        w_ctl.alu_src_b = SRCB_RS2;
        w_ctl.alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        w_ctl.alu_src_a = SRCA_RS1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_op    = ALU_FUNCT;
      end
      S_MEM_ADDR: begin
        w_ctl.alu_src_a = SRCA_RS1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        w_ctl.mem_req = 1'b1;
        w_ctl.iord    = 1'b1;
      end
      S_MEM_WR: begin
        w_ctl.mem_req = 1'b1;
        w_ctl.mem_we  = 1'b1;
        w_ctl.iord    = 1'b1;
      end
      S_WB_ALU: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = MTR_ALU;
      end
      S_WB_MEM: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = MTR_MDR;
      end
      S_BRANCH: begin
        w_ctl.alu_src_a = SRCA_RS1;
        w_ctl.alu_src_b = SRCB_RS2;
        w_ctl.alu_op    = ALU_SUB;
        w_ctl.pc_src    = 1'b1;
        w_ctl.pc_write  = zero_i;
      end
      S_JAL: begin
        w_ctl.pc_write   = 1'b1;
        w_ctl.pc_src     = 1'b1;
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = MTR_PC;
      end
      default: w_ctl = '0;
    endcase
  end

  // Reset gates every output combinationally so nothing, not even the FETCH
  // request, escapes while rst_i is held low.
  assign pc_write_o   = rst_i & w_ctl.pc_write;
  assign ir_write_o   = rst_i & w_ctl.ir_write;
  assign mem_req_o    = rst_i & w_ctl.mem_req;
  assign mem_we_o     = rst_i & w_ctl.mem_we;
  assign iord_o       = rst_i & w_ctl.iord;
  assign reg_write_o  = rst_i & w_ctl.reg_write;
  assign mem_to_reg_o = rst_i ? w_ctl.mem_to_reg : 2'b00;
  assign alu_src_a_o  = rst_i ? w_ctl.alu_src_a  : 2'b00;
  assign alu_src_b_o  = rst_i ? w_ctl.alu_src_b  : 2'b00;
  assign alu_op_o     = rst_i ? w_ctl.alu_op     : 2'b00;
  assign pc_src_o     = rst_i & w_ctl.pc_src;
  assign state_o      = rst_i ? r_state          : 4'd0;
  assign trap_o       = rst_i & r_trap;
  assign trap_cause_o = rst_i ? r_cause          : 2'b00;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [6:0] opcode_i;
  logic       zero_i;
  logic       mem_ack_i;
  logic       pc_write_o, ir_write_o, mem_req_o, mem_we_o, iord_o, reg_write_o;
  logic [1:0] mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o;
  logic       pc_src_o;
  logic [3:0] state_o;
  logic       trap_o;
  logic [1:0] trap_cause_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  multi_cycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .opcode_i     (opcode_i),
    .zero_i       (zero_i),
    .mem_ack_i    (mem_ack_i),
    .pc_write_o   (pc_write_o),
    .ir_write_o   (ir_write_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .iord_o       (iord_o),
    .reg_write_o  (reg_write_o),
    .mem_to_reg_o (mem_to_reg_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .pc_src_o     (pc_src_o),
    .state_o      (state_o),
    .trap_o       (trap_o),
    .trap_cause_o (trap_cause_o)
  );

  logic [17:0] w_obs;
  assign w_obs = {pc_write_o, ir_write_o, mem_req_o, mem_we_o, iord_o, reg_write_o,
                  mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o,
                  trap_o, trap_cause_o};

  // State codes as listed in the state enumeration order.
  localparam logic [3:0] F = 4'd0, D = 4'd1, XR = 4'd2, XI = 4'd3, MA = 4'd4,
                         MR = 4'd5, MW = 4'd6, WA = 4'd7, WM = 4'd8, BR = 4'd9,
                         JL = 4'd10, TR = 4'd11;

  function automatic logic [17:0] mk(input logic pw, input logic irw, input logic req,
                                     input logic we, input logic iord, input logic rw,
                                     input logic [1:0] m2r, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] op,
                                     input logic pcs, input logic trap,
                                     input logic [1:0] cause);
    return {pw, irw, req, we, iord, rw, m2r, sa, sb, op, pcs, trap, cause};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven for this cycle; check, then advance one clock.
  task automatic step(input string tag, input logic [3:0] est, input logic [17:0] ev);
    #1;
    chk({tag, ":state"}, {28'd0, state_o}, {28'd0, est});
    chk({tag, ":ctl"}, {14'd0, w_obs}, {14'd0, ev});
    @(posedge clk_i);
    #1;
  endtask

  // Expected control words for each state, written from the state table.
  logic [17:0] e_f_ack, e_f_wait, e_dec, e_xr, e_xi, e_ma, e_mr, e_mw, e_wa, e_wm;
  logic [17:0] e_br1, e_br0, e_jal, e_trap_ill, e_trap_to;

  initial begin
    e_f_ack    = mk(1,1,1,0,0,0,2'b00,2'b00,2'b01,2'b00,0,0,2'b00);
    e_f_wait   = mk(0,0,1,0,0,0,2'b00,2'b00,2'b01,2'b00,0,0,2'b00);
    e_dec      = mk(0,0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,0,0,2'b00);
    e_xr       = mk(0,0,0,0,0,0,2'b00,2'b01,2'b00,2'b10,0,0,2'b00);
    e_xi       = mk(0,0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,0,0,2'b00);
    e_ma       = mk(0,0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0,2'b00);
    e_mr       = mk(0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,2'b00);
    e_mw       = mk(0,0,1,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0,2'b00);
    e_wa       = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,0,2'b00);
    e_wm       = mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,0,0,2'b00);
    e_br1      = mk(1,0,0,0,0,0,2'b00,2'b01,2'b00,2'b01,1,0,2'b00);
    e_br0      = mk(0,0,0,0,0,0,2'b00,2'b01,2'b00,2'b01,1,0,2'b00);
    e_jal      = mk(1,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,1,0,2'b00);
    e_trap_ill = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,2'b01);
    e_trap_to  = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,2'b10);

    rst_i = 1'b0; opcode_i = 7'b0110011; zero_i = 1'b0; mem_ack_i = 1'b1;
    @(posedge clk_i); #1;
    // In reset: everything zero even though the FSM sits in FETCH with ack high.
    step("reset", F, '0);
    rst_i = 1'b1;

    // add: F, D, EXEC_R, WB_ALU, back to FETCH.
    mem_ack_i = 1'b1; step("add_f", F, e_f_ack);
    mem_ack_i = 1'b0; step("add_d", D, e_dec);
    step("add_x", XR, e_xr);
    step("add_wb", WA, e_wa);

    // addi: same length via EXEC_I.
    opcode_i = 7'b0010011;
    mem_ack_i = 1'b1; step("addi_f", F, e_f_ack);
    mem_ack_i = 1'b0; step("addi_d", D, e_dec);
    step("addi_x", XI, e_xi);
    step("addi_wb", WA, e_wa);

    // lw: stray acks while no request must be ignored; data ack on 4th cycle.
    opcode_i = 7'b0000011;
    mem_ack_i = 1'b1; step("lw_f", F, e_f_ack);
    step("lw_d", D, e_dec);
    step("lw_ma", MA, e_ma);
    mem_ack_i = 1'b0;
    step("lw_rd1", MR, e_mr);
    step("lw_rd2", MR, e_mr);
    step("lw_rd3", MR, e_mr);
    mem_ack_i = 1'b1; step("lw_rd4", MR, e_mr);
    mem_ack_i = 1'b0; step("lw_wb", WM, e_wm);

    // beq taken then not taken.
    opcode_i = 7'b1100011;
    mem_ack_i = 1'b1; step("beq1_f", F, e_f_ack);
    mem_ack_i = 1'b0; step("beq1_d", D, e_dec);
    zero_i = 1'b1; step("beq1_br", BR, e_br1);
    zero_i = 1'b0;
    mem_ack_i = 1'b1; step("beq0_f", F, e_f_ack);
    mem_ack_i = 1'b0; step("beq0_d", D, e_dec);
    step("beq0_br", BR, e_br0);

    // jal.
    opcode_i = 7'b1101111;
    mem_ack_i = 1'b1; step("jal_f", F, e_f_ack);
    mem_ack_i = 1'b0; step("jal_d", D, e_dec);
    step("jal_j", JL, e_jal);

    // sw with zero-wait write.
    opcode_i = 7'b0100011;
    mem_ack_i = 1'b1; step("sw_f", F, e_f_ack);
    mem_ack_i = 1'b0; step("sw_d", D, e_dec);
    step("sw_ma", MA, e_ma);
    mem_ack_i = 1'b1; step("sw_wr", MW, e_mw);

    // sw stalled, then reset in the middle of the write wait.
    mem_ack_i = 1'b1; step("sw2_f", F, e_f_ack);
    mem_ack_i = 1'b0; step("sw2_d", D, e_dec);
    step("sw2_ma", MA, e_ma);
    step("sw2_wr1", MW, e_mw);
    rst_i = 1'b0; step("sw2_rst", F, '0);
    rst_i = 1'b1;

    // Fetch timeout: 4 cycles without ack, then TRAP with cause 10.
    step("to_f1", F, e_f_wait);
    step("to_f2", F, e_f_wait);
    step("to_f3", F, e_f_wait);
    step("to_f4", F, e_f_wait);
    step("to_trap", TR, e_trap_to);
    rst_i = 1'b0; step("to_rst", F, '0);
    rst_i = 1'b1;

    // Ack on the 4th wait cycle beats the timeout; opcode 0 is illegal.
    opcode_i = 7'b0000000;
    step("ack4_f1", F, e_f_wait);
    step("ack4_f2", F, e_f_wait);
    step("ack4_f3", F, e_f_wait);
    mem_ack_i = 1'b1; step("ack4_f4", F, e_f_ack);
    mem_ack_i = 1'b0; step("ill_d", D, e_dec);

    // TRAP must hold regardless of inputs for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      mem_ack_i = i[0];
      zero_i    = i[1];
      opcode_i  = 7'b0110011;
      step("ill_hold", TR, e_trap_ill);
    end
    mem_ack_i = 1'b0; zero_i = 1'b0;
    rst_i = 1'b0; step("ill_rst", F, '0);
    rst_i = 1'b1;
    step("ill_after", F, e_f_wait);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
